interface_controller: RTL and testbench
=======================================

INTERFACE_CONTROLLER -- requirements
Module: interface_controller

Interface
REQ-001 CLK  in  1  single system clock; all state changes on the rising edge.
REQ-002 RST  in  1  asynchronous, active-low reset.
REQ-003 upButton, downButton, leftButton, rightButton  in  1 each  cursor navigation requests, level inputs.
REQ-004 writeBit  in  1  request to write userNum into the cell under the cursor.
REQ-005 userNum  in  4  value to write; 0 clears the cell, 1-4 are legal digits, 5-15 are invalid.
REQ-006 currentRow  out  16  cell values of the cursor row; column c occupies bits [15-4c:12-4c].
REQ-007 currentNum  out  4  value of the cell under the cursor.
REQ-008 noWrite  out  1  1 when the cell under the cursor is write-protected.
REQ-009 RamAddr  out  2  RAM word address; always equals the cursor row.
REQ-010 RamDat  in  24  RAM read data.
REQ-011 RamWriteBuf  out  24  RAM write data.
REQ-012 RamWriteBit  out  1  RAM write enable.

Function
REQ-013 Each RAM word holds one puzzle row: bits [15:0] are cell values (layout per REQ-006), bit 19-c is the protect flag of column c, and bits [23:20] are reserved and written back unchanged.
REQ-014 The companion RAM is 4x24 with a registered address and 1-cycle read latency, so data for RamAddr is valid on the cycle after it is presented.
REQ-015 The cursor is a 2-bit row register and a 2-bit column register.
REQ-016 Each button and writeBit is rising-edge detected with one register per input, so a held input acts exactly once.
REQ-017 up decrements the row and down increments it, both modulo 4 (0->3 and 3->0 wrap).
REQ-018 left decrements the column and right increments it, both modulo 4.
REQ-019 The FSM has four states: FETCH, LOAD, IDLE and WRITE.
REQ-020 FETCH drives RamAddr and then moves to LOAD.
REQ-021 LOAD captures RamDat into a 24-bit row buffer and then moves to IDLE.
REQ-022 Edges are acted on only in IDLE, one per cycle, with priority write > up > down > left > right; edges arriving in other states are dropped.
REQ-023 A row move updates the row and then enters FETCH; a column move updates the column only and stays in IDLE with no RAM access.
REQ-024 A write edge in IDLE proceeds only when noWrite=0 and userNum<=4; otherwise it is ignored and the FSM stays in IDLE.
REQ-025 When a write proceeds, RamWriteBuf is registered as the buffer with the cursor cell replaced by userNum and all other bits unchanged.
REQ-026 In WRITE, RamWriteBit=1 for exactly one cycle, then the FSM enters FETCH to re-read the row.
REQ-027 RamWriteBit is 0 in every state other than WRITE.
REQ-028 currentRow, currentNum and noWrite are decoded from the row buffer and the cursor column; a column move updates them on the next cycle.
REQ-029 Latency: after a row move the new row is visible within 3 cycles; after a write the new value is visible within 4 cycles.

Reset
REQ-030 While RST=0: row=0, col=0, buffer=0, RamWriteBuf=0, RamWriteBit=0, edge registers=0, state=FETCH.
REQ-031 Consequently, during reset currentRow=0, currentNum=0, noWrite=0 and RamAddr=0.
REQ-032 After RST is released the controller automatically fetches row 0.
REQ-033 Reset asserted mid-write aborts the write, and RamWriteBit drops immediately.

Verification
Initial RAM image: row0 24'h020010, row1 24'h084000, row2 24'h010002, row3 24'h020030 (puzzle "_ _ 1 _ / 4 _ _ _ / _ _ _ 2 / _ _ 3 _", givens protected).
REQ-034 Release reset -> within 3 cycles currentRow=16'h0010, currentNum=0, noWrite=0, RamAddr=0.
REQ-035 Left pulse, then left held for 5 cycles -> column 3 then 2 (held counts once); currentNum=1, noWrite=1; two right pulses -> column 0, currentNum=0.
REQ-036 Up x2 -> RamAddr 3 then 2; currentRow=16'h0030 then 16'h0002; down x2 -> row 0, currentRow=16'h0010.
REQ-037 At (0,0), userNum=4 and writeBit pulse -> one cycle with RamWriteBit=1, RamAddr=0, RamWriteBuf=24'h024010; then currentRow=16'h4010, currentNum=4.
REQ-038 Right then left pulses -> currentNum=4 (value retained).
REQ-039 Move to (0,2), writeBit pulse -> RamWriteBit stays 0 and currentRow stays 16'h4010.
REQ-040 At an unprotected cell, userNum=7 and writeBit pulse -> no write.
REQ-041 Up and left asserted in the same cycle -> only the row changes.

Source files
------------

// File: rtl/interface_controller.sv
// Cursor/edit controller for a 4x4 puzzle grid held in a 4x24 synchronous RAM.
// One row is buffered locally; writes go back to RAM and the row is re-read.
module interface_controller (
    input  logic        CLK,
    input  logic        RST,
    input  logic        upButton,
    input  logic        downButton,
    input  logic        leftButton,
    input  logic        rightButton,
    input  logic        writeBit,
    input  logic [3:0]  userNum,
    output logic [15:0] currentRow,
    output logic [3:0]  currentNum,
    output logic        noWrite,
    output logic [1:0]  RamAddr,
    input  logic [23:0] RamDat,
    output logic [23:0] RamWriteBuf,
    output logic        RamWriteBit
);

    typedef enum logic [1:0] {S_FETCH, S_LOAD, S_IDLE, S_WRITE} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_up_q, r_down_q, r_left_q, r_right_q, r_write_q;
    logic        w_up_edge, w_down_edge, w_left_edge, w_right_edge, w_write_edge;
    logic [1:0]  r_row;
    logic [1:0]  r_col;
    logic [23:0] r_buf;
    logic [23:0] r_wbuf;
    logic [4:0]  w_shift;
    logic [3:0]  w_prot;
    logic        w_write_ok;
    logic [23:0] w_write_data;

    assign w_up_edge    = upButton    & ~r_up_q;
    assign w_down_edge  = downButton  & ~r_down_q;
    assign w_left_edge  = leftButton  & ~r_left_q;
    assign w_right_edge = rightButton & ~r_right_q;
    assign w_write_edge = writeBit    & ~r_write_q;

    // Column c lives at bit offset 4*(3-c); its protect flag is bit 19-c.
    assign w_shift      = {~r_col, 2'b00};
    assign w_prot       = r_buf[19:16];
    assign w_write_ok   = w_write_edge && !noWrite && (userNum <= 4'd4);
    assign w_write_data = (r_buf & ~(24'hF << w_shift)) | ({20'd0, userNum} << w_shift);

    assign currentRow   = r_buf[15:0];
    assign currentNum   = 4'(r_buf >> w_shift);
    assign noWrite      = w_prot[~r_col];
    assign RamAddr      = r_row;
    assign RamWriteBuf  = r_wbuf;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_IDLE;
            S_IDLE: begin
                if (w_write_edge) begin
                    if (w_write_ok) w_next_state = S_WRITE;
                end else if (w_up_edge || w_down_edge) begin
                    w_next_state = S_FETCH;
                end
            end
            S_WRITE: w_next_state = S_FETCH;
            default: w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        RamWriteBit = (r_state == S_WRITE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_up_q    <= 1'b0;
            r_down_q  <= 1'b0;
            r_left_q  <= 1'b0;
            r_right_q <= 1'b0;
            r_write_q <= 1'b0;
        end else begin
            r_up_q    <= upButton;
            r_down_q  <= downButton;
            r_left_q  <= leftButton;
            r_right_q <= rightButton;
            r_write_q <= writeBit;
        end
    end

    // Only one edge is serviced per IDLE cycle; the write edge wins even when refused.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_row  <= 2'd0;
            r_col  <= 2'd0;
            r_buf  <= 24'd0;
            r_wbuf <= 24'd0;
        end else begin
            if (r_state == S_LOAD) r_buf <= RamDat;
            if (r_state == S_IDLE) begin
                if (w_write_edge) begin
                    if (w_write_ok) r_wbuf <= w_write_data;
                end else if (w_up_edge) begin
                    r_row <= r_row - 2'd1;
                end else if (w_down_edge) begin
                    r_row <= r_row + 2'd1;
                end else if (w_left_edge) begin
                    r_col <= r_col - 2'd1;
                end else if (w_right_edge) begin
                    r_col <= r_col + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_interface_controller.sv
// Directed bench for interface_controller with a behavioural 4x24 RAM
// (registered address, one-cycle read latency) preloaded with a small puzzle.
module tb_interface_controller;

    localparam logic [4:0] B_WRITE = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;

    logic        CLK;
    logic        RST;
    logic        upButton, downButton, leftButton, rightButton, writeBit;
    logic [3:0]  userNum;
    logic [15:0] currentRow;
    logic [3:0]  currentNum;
    logic        noWrite;
    logic [1:0]  RamAddr;
    logic [23:0] RamDat;
    logic [23:0] RamWriteBuf;
    logic        RamWriteBit;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cycles = 0;
    int wr0;

    logic [23:0] mem [4];
    logic [1:0]  r_ram_addr;

    interface_controller dut (
        .CLK         (CLK),
        .RST         (RST),
        .upButton    (upButton),
        .downButton  (downButton),
        .leftButton  (leftButton),
        .rightButton (rightButton),
        .writeBit    (writeBit),
        .userNum     (userNum),
        .currentRow  (currentRow),
        .currentNum  (currentNum),
        .noWrite     (noWrite),
        .RamAddr     (RamAddr),
        .RamDat      (RamDat),
        .RamWriteBuf (RamWriteBuf),
        .RamWriteBit (RamWriteBit)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RamWriteBit) mem[RamAddr] <= RamWriteBuf;
        r_ram_addr <= RamAddr;
    end
    assign RamDat = mem[r_ram_addr];

    always @(negedge CLK) if (RamWriteBit) wr_cycles++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Raise the selected inputs for one cycle, then hold them low for one cycle.
    task automatic pulse(input logic [4:0] m);
        {writeBit, upButton, downButton, leftButton, rightButton} = m;
        tick(1);
        {writeBit, upButton, downButton, leftButton, rightButton} = 5'b0;
        tick(1);
    endtask

    task automatic test_reset;
        tick(2);
        n_checks++; if (currentRow !== 16'h0000) begin n_fail++; $display("FAIL rst_row: got %h expected 0000", currentRow); end
        n_checks++; if (currentNum !== 4'h0) begin n_fail++; $display("FAIL rst_num: got %h expected 0", currentNum); end
        n_checks++; if (noWrite !== 1'b0) begin n_fail++; $display("FAIL rst_nowrite: got %b expected 0", noWrite); end
        n_checks++; if (RamAddr !== 2'd0) begin n_fail++; $display("FAIL rst_addr: got %0d expected 0", RamAddr); end
        n_checks++; if (RamWriteBit !== 1'b0) begin n_fail++; $display("FAIL rst_wbit: got %b expected 0", RamWriteBit); end
        n_checks++; if (RamWriteBuf !== 24'h0) begin n_fail++; $display("FAIL rst_wbuf: got %h expected 000000", RamWriteBuf); end
        RST = 1'b1;
        tick(3);
        n_checks++; if (currentRow !== 16'h0010) begin n_fail++; $display("FAIL boot_row: got %h expected 0010", currentRow); end
        n_checks++; if (currentNum !== 4'h0) begin n_fail++; $display("FAIL boot_num: got %h expected 0", currentNum); end
        n_checks++; if (noWrite !== 1'b0) begin n_fail++; $display("FAIL boot_nowrite: got %b expected 0", noWrite); end
        n_checks++; if (RamAddr !== 2'd0) begin n_fail++; $display("FAIL boot_addr: got %0d expected 0", RamAddr); end
    endtask

    task automatic test_column;
        pulse(B_LEFT);
        n_checks++; if (noWrite !== 1'b0 || currentNum !== 4'h0) begin n_fail++; $display("FAIL col3: got num %h nw %b expected 0 0", currentNum, noWrite); end
        leftButton = 1'b1;
        tick(5);
        leftButton = 1'b0;
        tick(1);
        n_checks++; if (currentNum !== 4'h1) begin n_fail++; $display("FAIL col2_num: got %h expected 1", currentNum); end
        n_checks++; if (noWrite !== 1'b1) begin n_fail++; $display("FAIL col2_nowrite: got %b expected 1", noWrite); end
        pulse(B_RIGHT);
        pulse(B_RIGHT);
        n_checks++; if (currentNum !== 4'h0 || noWrite !== 1'b0) begin n_fail++; $display("FAIL col0: got num %h nw %b expected 0 0", currentNum, noWrite); end
        n_checks++; if (RamAddr !== 2'd0) begin n_fail++; $display("FAIL col_addr: got %0d expected 0", RamAddr); end
    endtask

    task automatic test_row;
        pulse(B_UP); tick(1);
        n_checks++; if (RamAddr !== 2'd3 || currentRow !== 16'h0030) begin n_fail++; $display("FAIL up1: got addr %0d row %h expected 3 0030", RamAddr, currentRow); end
        pulse(B_UP); tick(1);
        n_checks++; if (RamAddr !== 2'd2 || currentRow !== 16'h0002) begin n_fail++; $display("FAIL up2: got addr %0d row %h expected 2 0002", RamAddr, currentRow); end
        pulse(B_DOWN); tick(1);
        n_checks++; if (RamAddr !== 2'd3 || currentRow !== 16'h0030) begin n_fail++; $display("FAIL down1: got addr %0d row %h expected 3 0030", RamAddr, currentRow); end
        pulse(B_DOWN); tick(1);
        n_checks++; if (RamAddr !== 2'd0 || currentRow !== 16'h0010) begin n_fail++; $display("FAIL down2: got addr %0d row %h expected 0 0010", RamAddr, currentRow); end
    endtask

    task automatic test_write;
        userNum = 4'd4;
        wr0 = wr_cycles;
        writeBit = 1'b1;
        tick(1);
        n_checks++; if (RamWriteBit !== 1'b1) begin n_fail++; $display("FAIL wr_bit: got %b expected 1", RamWriteBit); end
        n_checks++; if (RamAddr !== 2'd0) begin n_fail++; $display("FAIL wr_addr: got %0d expected 0", RamAddr); end
        n_checks++; if (RamWriteBuf !== 24'h024010) begin n_fail++; $display("FAIL wr_buf: got %h expected 024010", RamWriteBuf); end
        writeBit = 1'b0;
        tick(1);
        n_checks++; if (RamWriteBit !== 1'b0) begin n_fail++; $display("FAIL wr_bit_drop: got %b expected 0", RamWriteBit); end
        tick(2);
        n_checks++; if (currentRow !== 16'h4010) begin n_fail++; $display("FAIL wr_row: got %h expected 4010", currentRow); end
        n_checks++; if (currentNum !== 4'h4) begin n_fail++; $display("FAIL wr_num: got %h expected 4", currentNum); end
        n_checks++; if (wr_cycles - wr0 != 1) begin n_fail++; $display("FAIL wr_count: got %0d expected 1", wr_cycles - wr0); end
    endtask

    task automatic test_retain;
        pulse(B_RIGHT);
        pulse(B_LEFT);
        n_checks++; if (currentNum !== 4'h4) begin n_fail++; $display("FAIL retain: got %h expected 4", currentNum); end
    endtask

    task automatic test_protected;
        pulse(B_RIGHT);
        pulse(B_RIGHT);
        n_checks++; if (noWrite !== 1'b1) begin n_fail++; $display("FAIL prot_flag: got %b expected 1", noWrite); end
        userNum = 4'd4;
        wr0 = wr_cycles;
        pulse(B_WRITE); tick(3);
        n_checks++; if (wr_cycles != wr0) begin n_fail++; $display("FAIL prot_nowr: got %0d writes expected 0", wr_cycles - wr0); end
        n_checks++; if (currentRow !== 16'h4010 || currentNum !== 4'h1) begin n_fail++; $display("FAIL prot_row: got %h num %h expected 4010 1", currentRow, currentNum); end
    endtask

    task automatic test_invalid;
        pulse(B_LEFT);
        n_checks++; if (noWrite !== 1'b0) begin n_fail++; $display("FAIL inv_flag: got %b expected 0", noWrite); end
        userNum = 4'd7;
        wr0 = wr_cycles;
        pulse(B_WRITE); tick(3);
        userNum = 4'd5;
        pulse(B_WRITE); tick(3);
        n_checks++; if (wr_cycles != wr0) begin n_fail++; $display("FAIL inv_nowr: got %0d writes expected 0", wr_cycles - wr0); end
        n_checks++; if (currentRow !== 16'h4010) begin n_fail++; $display("FAIL inv_row: got %h expected 4010", currentRow); end
    endtask

    task automatic test_simultaneous;
        pulse(B_RIGHT);
        pulse(B_UP | B_LEFT); tick(1);
        n_checks++; if (RamAddr !== 2'd3 || currentRow !== 16'h0030) begin n_fail++; $display("FAIL sim_row: got addr %0d row %h expected 3 0030", RamAddr, currentRow); end
        n_checks++; if (currentNum !== 4'h3 || noWrite !== 1'b1) begin n_fail++; $display("FAIL sim_col: got num %h nw %b expected 3 1", currentNum, noWrite); end
    endtask

    task automatic test_reset_mid_write;
        pulse(B_LEFT);
        userNum = 4'd2;
        writeBit = 1'b1;
        tick(1);
        n_checks++; if (RamWriteBit !== 1'b1 || RamWriteBuf !== 24'h020230) begin n_fail++; $display("FAIL mid_wr: got bit %b buf %h expected 1 020230", RamWriteBit, RamWriteBuf); end
        #2 RST = 1'b0;
        #1;
        n_checks++; if (RamWriteBit !== 1'b0) begin n_fail++; $display("FAIL mid_abort: got %b expected 0", RamWriteBit); end
        n_checks++; if (RamAddr !== 2'd0 || currentRow !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_out: got addr %0d row %h expected 0 0000", RamAddr, currentRow); end
        writeBit = 1'b0;
        tick(2);
        RST = 1'b1;
        tick(3);
        n_checks++; if (currentRow !== 16'h4010 || currentNum !== 4'h4) begin n_fail++; $display("FAIL mid_boot: got row %h num %h expected 4010 4", currentRow, currentNum); end
        pulse(B_UP); tick(1);
        n_checks++; if (currentRow !== 16'h0030) begin n_fail++; $display("FAIL mid_row3: got %h expected 0030", currentRow); end
    endtask

    initial begin
        mem[0] = 24'h020010;
        mem[1] = 24'h084000;
        mem[2] = 24'h010002;
        mem[3] = 24'h020030;
        RST = 1'b0;
        {writeBit, upButton, downButton, leftButton, rightButton} = 5'b0;
        userNum = 4'd0;
        test_reset;
        test_column;
        test_row;
        test_write;
        test_retain;
        test_protected;
        test_invalid;
        test_simultaneous;
        test_reset_mid_write;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
